// File: rtl/display_pkg.sv
// Shared seven-segment constants and the BCD digit type used by the display
// driver and the time counters.
package display_pkg;

  typedef logic [3:0] bcd_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment pattern; codes above 9 show a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  bcd_t       i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/hhmm_display_mux.sv
// Four-digit HH:MM scan driver: frame-coherent digit snapshot, per-slot
// anti-ghosting blank, leading-zero suppression and a blinking colon.
module hhmm_display_mux
  import display_pkg::*;
#(
  parameter int SCAN_DIV           = 1000,
  parameter int BLANK_CYCLES       = 50,
  parameter int BLANK_LEADING_ZERO = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] hour_tens,
  input  logic       sec_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_slot;
  bcd_t [3:0]      r_snap;
  logic            r_colon;

  logic [CW-1:0]   w_cnt_nxt;
  logic [1:0]      w_slot_nxt;
  bcd_t [3:0]      w_snap_nxt;
  logic            w_colon_nxt;
  logic            w_wrap;
  logic            w_frame_start;
  logic            w_drive;
  logic            w_dark;
  logic            w_on;
  bcd_t            w_digit;
  logic [6:0]      w_seg_pat;

  assign w_wrap        = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_cnt_nxt     = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_slot_nxt    = w_wrap ? r_slot + 2'd1 : r_slot;
  assign w_frame_start = (r_slot == 2'd0) && (r_cnt == '0);
  assign w_colon_nxt   = r_colon ^ sec_tick;

  // Outputs are registered from next-state values so they line up with the
  // slot/cnt held in the same cycle; the snapshot follows the same rule.
  assign w_snap_nxt = w_frame_start ? {hour_tens, hour_ones, min_tens, min_ones} : r_snap;
  assign w_digit    = w_snap_nxt[w_slot_nxt];

  assign w_drive = (w_cnt_nxt >= CW'(BLANK_CYCLES));
  assign w_dark  = (BLANK_LEADING_ZERO != 0) && (w_slot_nxt == 2'd3) && (w_snap_nxt[3] == 4'd0);
  assign w_on    = w_drive && !w_dark;

  bcd_to_7seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg_pat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_slot  <= 2'd0;
      r_snap  <= '0;
      r_colon <= 1'b1;
      an      <= 4'b0000;
      seg     <= SEG_OFF;
      dp      <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_slot  <= w_slot_nxt;
      r_snap  <= w_snap_nxt;
      r_colon <= w_colon_nxt;
      an      <= w_on ? (4'd1 << w_slot_nxt) : 4'b0000;
      seg     <= w_on ? w_seg_pat : SEG_OFF;
      dp      <= w_on && w_colon_nxt && (w_slot_nxt == 2'd2);
    end
  end

endmodule
